// File: rtl/fetch_pc_unit.sv
// Fetch PC register, single-outstanding instruction-memory requester and one-entry decode buffer.
// Optional FETCH_MISALIGN_TRAP_EN: a redirect to a target with bit 1 set halts fetch and raises fetch_err.
`timescale 1ns/1ps
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exec_valid,
    input  logic [1:0]  b_ctrl,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_err
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_t;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        discard, discard_n;
    logic        vld_n;
    logic [31:0] instr_n, ifpc_n;
    logic        redirect;
    logic [31:0] tgt_raw, tgt;

    assign redirect = exec_valid && !b_ctrl[1];
    assign tgt_raw  = b_ctrl[0] ? br_target : {jalr_target[31:1], 1'b0};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic err_q, err_n;
    assign tgt       = tgt_raw;
    assign fetch_err = err_q;
`else
    // Without the trap, targets are word-aligned by dropping bit 1.
    assign tgt       = {tgt_raw[31:2], 1'b0, tgt_raw[0]};
    assign fetch_err = 1'b0;
`endif

    // Requests only go out when the buffer is free, so a response always has room.
    assign imem_req  = (state == S_REQ) && (!if_valid || !stall);
    assign imem_addr = pc;

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        discard_n = discard;
        vld_n     = if_valid;
        instr_n   = if_instr;
        ifpc_n    = if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        err_n     = err_q;
`endif
        if (if_valid && !stall)
            vld_n = 1'b0;

        case (state)
            S_BOOT: state_n = S_REQ;
            S_REQ: begin
                if (imem_req && imem_gnt) begin
                    state_n   = S_WAIT;
                    discard_n = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_n   = S_REQ;
                    discard_n = 1'b0;
                    if (!discard && !redirect) begin
                        vld_n   = 1'b1;
                        instr_n = imem_rdata;
                        ifpc_n  = pc;
                        pc_n    = pc + 32'd4;
                    end
                end else if (redirect) begin
                    discard_n = 1'b1;
                end
            end
            default: ;
        endcase

        // Redirect overrides any load or consume decided above.
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect && state != S_HALT) begin
            pc_n  = tgt;
            vld_n = 1'b0;
            if (tgt[1]) begin
                state_n = S_HALT;
                err_n   = 1'b1;
            end
        end
`else
        if (redirect) begin
            pc_n  = tgt;
            vld_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            discard  <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= NOP;
            if_pc    <= RESET_PC;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            discard  <= discard_n;
            if_valid <= vld_n;
            if_instr <= instr_n;
            if_pc    <= ifpc_n;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_n;
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a small latency-programmable instruction memory.
`timescale 1ns/1ps
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst_n, exec_valid, stall;
    logic [1:0]  b_ctrl;
    logic [31:0] br_target, jalr_target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, fetch_err;
    logic [31:0] if_instr, if_pc;

    int n_chk = 0;
    int n_err = 0;

    // Memory model: response word = {addr[15:0], 16'h0013}, rvalid lat cycles after grant.
    logic        gnt_en = 1'b1;
    logic        rv_en  = 1'b1;
    int          lat    = 1;
    logic        pend   = 1'b0;
    int          cnt    = 0;
    logic [31:0] paddr  = 32'h0;

    always #5 clk = ~clk;

    assign imem_gnt    = imem_req && gnt_en;
    assign imem_rvalid = pend && (cnt == 0) && rv_en;
    assign imem_rdata  = imem_rvalid ? {paddr[15:0], 16'h0013} : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (imem_rvalid) pend <= 1'b0;
        else if (pend && cnt > 0) cnt <= cnt - 1;
        if (imem_req && imem_gnt) begin
            pend  <= 1'b1;
            paddr <= imem_addr;
            cnt   <= lat - 1;
        end
    end

    fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .exec_valid(exec_valid), .b_ctrl(b_ctrl),
        .br_target(br_target), .jalr_target(jalr_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; exec_valid = 1'b0; stall = 1'b0; b_ctrl = 2'd2;
        br_target = 32'h0; jalr_target = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req",   imem_req,  0);
        chk("rst_addr",  imem_addr, 32'h100);
        chk("rst_vld",   if_valid,  0);
        chk("rst_instr", if_instr,  32'h13);
        chk("rst_pc",    if_pc,     32'h100);
        chk("rst_err",   fetch_err, 0);
        rst_n = 1'b1;

        // Zero-wait memory, no stall
        @(negedge clk);
        chk("c1_req",  imem_req,  1);
        chk("c1_addr", imem_addr, 32'h100);
        chk("c1_vld",  if_valid,  0);
        @(negedge clk);
        chk("c2_req",  imem_req,  0);
        chk("c2_vld",  if_valid,  0);
        @(negedge clk);
        chk("c3_vld",   if_valid,  1);
        chk("c3_pc",    if_pc,     32'h100);
        chk("c3_instr", if_instr,  32'h0100_0013);
        chk("c3_addr",  imem_addr, 32'h104);
        chk("c3_req",   imem_req,  1);
        @(negedge clk);
        chk("c4_vld",  if_valid,  0);
        @(negedge clk);
        chk("c5_vld",  if_valid,  1);
        chk("c5_pc",   if_pc,     32'h104);
        chk("c5_addr", imem_addr, 32'h108);

        // Stall with full buffer
        stall = 1'b1;
        #1 chk("stall_req0", imem_req, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_vld",   if_valid, 1);
            chk("stall_pc",    if_pc,    32'h104);
            chk("stall_instr", if_instr, 32'h0104_0013);
            chk("stall_req",   imem_req, 0);
        end
        stall = 1'b0;
        #1;
        chk("resume_req",  imem_req,  1);
        chk("resume_addr", imem_addr, 32'h108);
        @(negedge clk);
        chk("resume_vld0", if_valid, 0);
        @(negedge clk);
        chk("resume_vld1", if_valid, 1);
        chk("resume_pc",   if_pc,    32'h108);
        lat = 3;

        // Branch redirect while WAIT, late response must be dropped
        @(negedge clk);
        exec_valid = 1'b1; b_ctrl = 2'd1; br_target = 32'h200;
        @(negedge clk);
        exec_valid = 1'b0; b_ctrl = 2'd2;
        chk("br_vld", if_valid, 0);
        chk("br_req", imem_req, 0);
        @(negedge clk);
        chk("br_late_req", imem_req, 0);
        @(negedge clk);
        chk("br_vld2", if_valid,  0);
        chk("br_req2", imem_req,  1);
        chk("br_addr", imem_addr, 32'h200);
        lat = 1;
        @(negedge clk);
        chk("br_wait_vld", if_valid, 0);
        @(negedge clk);
        chk("br_new_vld",   if_valid,  1);
        chk("br_new_pc",    if_pc,     32'h200);
        chk("br_new_instr", if_instr,  32'h0200_0013);
        chk("br_new_addr",  imem_addr, 32'h204);

        // JALR redirect coinciding with a grant in REQ
        exec_valid = 1'b1; b_ctrl = 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
        jalr_target = 32'h306;
        @(negedge clk);
        exec_valid = 1'b0; b_ctrl = 2'd2;
        chk("trap_err", fetch_err, 1);
        chk("trap_vld", if_valid,  0);
        chk("trap_req", imem_req,  0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_req", imem_req,  0);
            chk("halt_err", fetch_err, 1);
            chk("halt_vld", if_valid,  0);
        end
`else
        jalr_target = 32'h305;
        @(negedge clk);
        exec_valid = 1'b0; b_ctrl = 2'd2;
        chk("jalr_vld", if_valid,  0);
        chk("jalr_req", imem_req,  0);
        chk("jalr_err", fetch_err, 0);
        @(negedge clk);
        chk("jalr_req2", imem_req,  1);
        chk("jalr_addr", imem_addr, 32'h304);
        chk("jalr_err2", fetch_err, 0);
        chk("jalr_vld2", if_valid,  0);
`endif
        rst_n = 1'b0;
        #1;
        chk("rst2_err", fetch_err, 0);
        chk("rst2_req", imem_req,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wraparound from 32'hFFFF_FFFC
        @(negedge clk);
        chk("w_req",  imem_req,  1);
        chk("w_addr", imem_addr, 32'h100);
        gnt_en = 1'b0;
        exec_valid = 1'b1; b_ctrl = 2'd1; br_target = 32'hFFFF_FFFC;
        @(negedge clk);
        exec_valid = 1'b0; b_ctrl = 2'd2; gnt_en = 1'b1;
        chk("w_top_addr", imem_addr, 32'hFFFF_FFFC);
        chk("w_top_req",  imem_req,  1);
        @(negedge clk);
        @(negedge clk);
        chk("w_vld",   if_valid,  1);
        chk("w_pc",    if_pc,     32'hFFFF_FFFC);
        chk("w_instr", if_instr,  32'hFFFC_0013);
        chk("w_addr0", imem_addr, 32'h0);
        chk("w_req0",  imem_req,  1);

        // Asynchronous reset while WAIT, then stale response in BOOT
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_addr",  imem_addr, 32'h100);
        chk("ar_vld",   if_valid,  0);
        chk("ar_pc",    if_pc,     32'h100);
        chk("ar_instr", if_instr,  32'h13);
        chk("ar_req",   imem_req,  0);
        chk("ar_err",   fetch_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("stale_req",  imem_req,  1);
        chk("stale_addr", imem_addr, 32'h100);
        chk("stale_vld",  if_valid,  0);
        @(negedge clk);
        chk("stale_vld2", if_valid, 0);
        @(negedge clk);
        chk("post_vld",   if_valid, 1);
        chk("post_pc",    if_pc,    32'h100);
        chk("post_instr", if_instr, 32'h0100_0013);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
